// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   // Access sequencer states
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam int unsigned WORD_BYTES = 8;
   localparam logic [2:0]  ALIGN_MASK = 3'(WORD_BYTES - 1);

   // A byte address is word aligned when its low offset bits are all zero
   function automatic logic is_aligned(input logic [2:0] lsb);
      return (lsb & ALIGN_MASK) == 3'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin arbiter. Under contention the input
//               that did not win last time is granted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,      // asynchronous, active low
   input  logic [1:0] req_i,
   input  logic       update_i,   // commit the current grant to history
   output logic       valid_o,
   output logic       gnt_id_o
);

   logic last_grant_q;
   logic last_grant_d;

   // Grant selection and history update
   always_comb begin
      valid_o      = |req_i;
      gnt_id_o     = (req_i == 2'b11) ? ~last_grant_q : req_i[1];
      last_grant_d = last_grant_q;
      if (update_i && valid_o) begin
         last_grant_d = gnt_id_o;
      end
   end

   // History register; port 0 wins the first contention after reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port arbiter and access sequencer for the 64-byte data
//               memory. One strobe cycle per access, one-cycle acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int MEM_BYTES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              ack0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_memorywrite,
   output logic              mem_memoryread,
   input  logic [DATA_W-1:0] mem_read_data
);

   // Highest legal word address; compared unsigned on the full width
   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES) - ADDR_W'(WORD_BYTES);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              we_q, we_d;
   logic              id_q, id_d;
   logic              err_q, err_d;

   logic              gnt_valid;
   logic              gnt_id;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;
   logic              sel_legal;

   rr_arbiter2 u_arb (
      .clk      (clk),
      .reset    (reset),
      .req_i    ({req1, req0}),
      .update_i (state_q == S_IDLE),
      .valid_o  (gnt_valid),
      .gnt_id_o (gnt_id)
   );

   // Winner's request fields and the alignment / bounds check
   always_comb begin
      sel_addr  = gnt_id ? addr1  : addr0;
      sel_wdata = gnt_id ? wdata1 : wdata0;
      sel_we    = gnt_id ? we1    : we0;
      sel_legal = is_aligned(sel_addr[2:0]) && (sel_addr <= LAST_WORD);
   end

   // Next-state logic for the IDLE -> ACCESS -> RESP sequence
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      we_d    = we_q;
      id_d    = id_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_valid) begin
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               we_d    = sel_we;
               id_d    = gnt_id;
               rdata_d = '0;
               if (sel_legal) begin
                  err_d   = 1'b0;
                  state_d = S_ACCESS;
               end else begin
                  // Rejected requests skip the memory entirely
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_ACCESS: begin
            if (!we_q) begin
               rdata_d = mem_read_data;
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and transaction registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         id_q    <= id_d;
         err_q   <= err_d;
      end
   end

   // Outputs decoded from state so a reset mid-access drops strobes at once
   always_comb begin
      mem_memorywrite = (state_q == S_ACCESS) &&  we_q;
      mem_memoryread  = (state_q == S_ACCESS) && !we_q;
      mem_address     = addr_q;
      mem_write_data  = wdata_q;
      ack0            = (state_q == S_RESP) && !id_q;
      ack1            = (state_q == S_RESP) &&  id_q;
      err             = err_q;
      rdata           = rdata_q;
      busy            = (state_q != S_IDLE);
   end

endmodule
`default_nettype wire
